riscv_dbg_access_ctrl: RTL and testbench



---
 rtl/riscv_dbg_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_riscv_dbg_access_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dbg_access_ctrl.sv
// Debug-bus access sequencer: decodes debug addresses into Debug Unit banks,
// halts the core for GPR/CSR accesses and returns read data with a one-cycle ack.
module riscv_dbg_access_ctrl #(
    parameter int XLEN        = 32,
    parameter int BREAKPOINTS = 8,
    parameter bit HAS_FPU     = 1'b0,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dbg_stall_i,
    input  logic            dbg_strb,
    input  logic            dbg_we,
    input  logic [15:0]     dbg_addr,
    input  logic [XLEN-1:0] dbg_dati,
    output logic [XLEN-1:0] dbg_dato,
    output logic            dbg_ack,
    output logic            dbg_err,
    output logic            du_stall,
    input  logic            cpu_halted,
    output logic [11:0]     du_addr,
    output logic            du_we,
    output logic [XLEN-1:0] du_dato,
    output logic            du_int_strb,
    output logic            du_gpr_strb,
    output logic            du_csr_strb,
    input  logic [XLEN-1:0] du_int_rdata,
    input  logic [XLEN-1:0] du_gpr_rdata,
    input  logic [XLEN-1:0] du_csr_rdata,
    input  logic            du_csr_ack
);
    localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
    localparam logic [11:0]   BP_END = 12'(16 + 2 * BREAKPOINTS);

    typedef enum logic [2:0] {IDLE, WAIT_HALT, ACCESS, WAIT_CSR, ACK} state_t;
    typedef enum logic [1:0] {BANK_INT, BANK_GPR, BANK_CSR} bank_t;

    state_t            state_q, state_d;
    bank_t             bank_q;
    logic              armed_q, we_q, err_q, core_q, stall_q;
    logic [11:0]       addr_q;
    logic [XLEN-1:0]   wdata_q, rdata_q;
    logic [CW-1:0]     cnt_q;

    logic [3:0]        req_bank;
    logic [11:0]       req_off;
    logic              req_legal, accept, core_d, timeout;

    assign req_bank = dbg_addr[15:12];
    assign req_off  = dbg_addr[11:0];
    // A held strobe cannot retrigger: armed is only restored by a low strobe in IDLE.
    assign accept   = (state_q == IDLE) && dbg_strb && armed_q;
    assign timeout  = (cnt_q == TMO);
    assign core_d   = accept ? (req_legal && (req_bank != 4'd0)) : core_q;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        req_legal = 1'b0;
        case (req_bank)
            4'd0: req_legal = (req_off <= 12'h003)
                           || ((req_off >= 12'h010) && (req_off < BP_END));
            4'd1: req_legal = (req_off <= 12'h01F)
                           || (HAS_FPU && (req_off >= 12'h100) && (req_off <= 12'h11F))
                           || (req_off == 12'h200) || (req_off == 12'h201);
            4'd2: req_legal = 1'b1;
            default: req_legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_legal)                 state_d = ACK;
                    else if (req_bank == 4'd0)      state_d = ACCESS;
                    else if (cpu_halted && stall_q) state_d = ACCESS;
                    else                            state_d = WAIT_HALT;
                end
            end
            WAIT_HALT: begin
                if (cpu_halted)   state_d = ACCESS;
                else if (timeout) state_d = ACK;
            end
            ACCESS:   state_d = (bank_q == BANK_CSR) ? WAIT_CSR : ACK;
            WAIT_CSR: if (du_csr_ack || timeout) state_d = ACK;
            ACK:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        dbg_ack     = (state_q == ACK);
        dbg_err     = dbg_ack && err_q;
        dbg_dato    = (dbg_ack && !we_q && !err_q) ? rdata_q : '0;
        du_int_strb = (state_q == ACCESS) && (bank_q == BANK_INT);
        du_gpr_strb = (state_q == ACCESS) && (bank_q == BANK_GPR);
        du_csr_strb = (state_q == ACCESS) && (bank_q == BANK_CSR);
        du_we       = (state_q == ACCESS) && we_q;
        du_addr     = addr_q;
        du_dato     = wdata_q;
        du_stall    = stall_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed_q <= 1'b1;
            bank_q  <= BANK_INT;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            core_q  <= 1'b0;
            stall_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if ((state_d == ACK) && (state_q != ACK)) armed_q <= 1'b0;
            else if ((state_q == IDLE) && !dbg_strb)  armed_q <= 1'b1;

            if (accept) begin
                bank_q  <= bank_t'(req_bank[1:0]);
                addr_q  <= req_off;
                we_q    <= dbg_we;
                wdata_q <= dbg_dati;
                rdata_q <= '0;
                err_q   <= !req_legal;
            end

            core_q  <= core_d;
            // Stall covers the whole GPR/CSR access through ACK, then follows dbg_stall_i alone.
            stall_q <= dbg_stall_i || ((state_d != IDLE) && core_d);

            case (state_q)
                WAIT_HALT: if (!cpu_halted && timeout) err_q <= 1'b1;
                ACCESS: begin
                    if (bank_q == BANK_INT)      rdata_q <= du_int_rdata;
                    else if (bank_q == BANK_GPR) rdata_q <= du_gpr_rdata;
                end
                WAIT_CSR: begin
                    if (du_csr_ack)   rdata_q <= du_csr_rdata;
                    else if (timeout) err_q   <= 1'b1;
                end
                default: ;
            endcase

            if (state_d != state_q)                                cnt_q <= '0;
            else if ((state_q == WAIT_HALT) || (state_q == WAIT_CSR)) cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_dbg_access_ctrl.sv
// Directed bench for riscv_dbg_access_ctrl: expected ack results go through a
// scoreboard queue, timing and strobe checks are made inline.
module tb_riscv_dbg_access_ctrl;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            dbg_stall_i, dbg_strb, dbg_we;
    logic [15:0]     dbg_addr;
    logic [XLEN-1:0] dbg_dati, dbg_dato;
    logic            dbg_ack, dbg_err, du_stall, cpu_halted;
    logic [11:0]     du_addr;
    logic            du_we;
    logic [XLEN-1:0] du_dato;
    logic            du_int_strb, du_gpr_strb, du_csr_strb;
    logic [XLEN-1:0] du_int_rdata, du_gpr_rdata, du_csr_rdata;
    logic            du_csr_ack;

    int n_checks  = 0;
    int n_fail    = 0;
    int ack_count = 0;

    typedef struct {
        logic [XLEN-1:0] dato;
        logic            err;
        string           tag;
    } exp_t;
    exp_t sb_q[$];

    riscv_dbg_access_ctrl #(
        .XLEN(XLEN), .BREAKPOINTS(4), .HAS_FPU(1'b0), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rstn(rstn), .dbg_stall_i(dbg_stall_i), .dbg_strb(dbg_strb),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_dati(dbg_dati), .dbg_dato(dbg_dato),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .du_stall(du_stall), .cpu_halted(cpu_halted),
        .du_addr(du_addr), .du_we(du_we), .du_dato(du_dato), .du_int_strb(du_int_strb),
        .du_gpr_strb(du_gpr_strb), .du_csr_strb(du_csr_strb), .du_int_rdata(du_int_rdata),
        .du_gpr_rdata(du_gpr_rdata), .du_csr_rdata(du_csr_rdata), .du_csr_ack(du_csr_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every ack pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && dbg_ack === 1'b1) begin
            ack_count++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL unexpected_ack: observed ack with dato %h, expected no ack", dbg_dato);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_dato"}, dbg_dato, e.dato);
                check({e.tag, "_err"}, {31'b0, dbg_err}, {31'b0, e.err});
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input logic [15:0] a, input logic we, input logic [31:0] d);
        dbg_addr = a;
        dbg_we   = we;
        dbg_dati = d;
        dbg_strb = 1'b1;
    endtask

    task automatic push(input logic [31:0] d, input logic err, input string tag);
        exp_t e;
        e.dato = d;
        e.err  = err;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    // Steps until dbg_ack is seen (bounded) and compares the cycle count.
    task automatic wait_ack(input string tag, input int exp_lat);
        int lat = 0;
        while (dbg_ack !== 1'b1 && lat < 64) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic gap();
        dbg_strb = 1'b0;
        step(2);
    endtask

    initial begin
        logic [15:0] ill_addr [3];
        int          acks_before;
        logic        any_strb;

        ill_addr = '{16'h3000, 16'h1100, 16'h0018};
        rstn = 1'b0;
        dbg_stall_i = 1'b0; dbg_strb = 1'b0; dbg_we = 1'b0;
        dbg_addr = '0; dbg_dati = '0; cpu_halted = 1'b0;
        du_int_rdata = '0; du_gpr_rdata = '0; du_csr_rdata = '0; du_csr_ack = 1'b0;
        step(2);

        // Reset values
        check("rst_ctrl", {25'b0, dbg_ack, dbg_err, du_stall, du_int_strb, du_gpr_strb,
                           du_csr_strb, du_we}, 32'h0);
        check("rst_dbg_dato", dbg_dato, 32'h0);
        check("rst_du_dato", du_dato, 32'h0);
        check("rst_du_addr", {20'b0, du_addr}, 32'h0);
        rstn = 1'b1;
        step(2);

        // Bank 0 read 0x0003
        du_int_rdata = 32'hA5;
        req(16'h0003, 1'b0, 32'h0);
        push(32'hA5, 1'b0, "b0_rd");
        step();
        check("b0_strb", {31'b0, du_int_strb}, 32'h1);
        check("b0_addr", {20'b0, du_addr}, 32'h003);
        check("b0_no_ack_yet", {31'b0, dbg_ack}, 32'h0);
        step();
        check("b0_ack", {31'b0, dbg_ack}, 32'h1);
        check("b0_stall", {31'b0, du_stall}, 32'h0);
        gap();

        // GPR write, core halts 3 cycles later
        req(16'h1005, 1'b1, 32'h1234);
        push(32'h0, 1'b0, "gpr_wr");
        step();
        check("gpr_stall_early", {31'b0, du_stall}, 32'h1);
        check("gpr_no_strb", {31'b0, du_gpr_strb}, 32'h0);
        step(2);
        cpu_halted = 1'b1;
        step();
        check("gpr_strb", {31'b0, du_gpr_strb}, 32'h1);
        check("gpr_we", {31'b0, du_we}, 32'h1);
        check("gpr_dato", du_dato, 32'h1234);
        check("gpr_addr", {20'b0, du_addr}, 32'h005);
        step();
        check("gpr_ack", {31'b0, dbg_ack}, 32'h1);
        check("gpr_stall_ack", {31'b0, du_stall}, 32'h1);
        dbg_strb = 1'b0;
        cpu_halted = 1'b0;
        step();
        check("gpr_stall_drop", {31'b0, du_stall}, 32'h0);
        step();

        // CSR read on an already halted, stalled core; csr ack after 5 cycles
        dbg_stall_i = 1'b1;
        cpu_halted  = 1'b1;
        step(2);
        du_csr_rdata = 32'h1800;
        req(16'h2300, 1'b0, 32'h0);
        push(32'h1800, 1'b0, "csr_rd");
        step();
        check("csr_strb", {31'b0, du_csr_strb}, 32'h1);
        check("csr_addr", {20'b0, du_addr}, 32'h300);
        step(5);
        check("csr_wait_no_ack", {31'b0, dbg_ack}, 32'h0);
        du_csr_ack = 1'b1;
        step();
        du_csr_ack = 1'b0;
        check("csr_ack", {31'b0, dbg_ack}, 32'h1);
        gap();

        // CSR ack coincides with the timeout cycle: ack wins
        du_csr_rdata = 32'hCAFE;
        req(16'h2001, 1'b0, 32'h0);
        push(32'hCAFE, 1'b0, "csr_ack_vs_to");
        step(17);
        check("csr_to_edge_no_ack", {31'b0, dbg_ack}, 32'h0);
        du_csr_ack = 1'b1;
        step();
        du_csr_ack = 1'b0;
        check("csr_to_edge_ack", {31'b0, dbg_ack}, 32'h1);
        gap();

        // CSR timeout
        req(16'h2010, 1'b0, 32'h0);
        push(32'h0, 1'b1, "csr_timeout");
        wait_ack("csr_timeout", 18);
        gap();
        dbg_stall_i = 1'b0;
        cpu_halted  = 1'b0;
        step(2);

        // Illegal addresses
        for (int i = 0; i < 3; i++) begin
            req(ill_addr[i], 1'b0, 32'h0);
            push(32'h0, 1'b1, $sformatf("illegal_%h", ill_addr[i]));
            step();
            check($sformatf("illegal_%h_ack", ill_addr[i]), {31'b0, dbg_ack}, 32'h1);
            check($sformatf("illegal_%h_strb", ill_addr[i]),
                  {29'b0, du_int_strb, du_gpr_strb, du_csr_strb}, 32'h0);
            check($sformatf("illegal_%h_stall", ill_addr[i]), {31'b0, du_stall}, 32'h0);
            gap();
        end

        // Highest implemented breakpoint offset is legal
        du_int_rdata = 32'h17;
        req(16'h0017, 1'b0, 32'h0);
        push(32'h17, 1'b0, "bp_last");
        wait_ack("bp_last", 2);
        gap();

        // Halt timeout
        req(16'h1001, 1'b0, 32'h0);
        push(32'h0, 1'b1, "halt_timeout");
        wait_ack("halt_timeout", 17);
        check("halt_timeout_stall", {31'b0, du_stall}, 32'h1);
        gap();

        // dbg_stall_i toggling during a GPR read
        du_gpr_rdata = 32'h5555AAAA;
        req(16'h1010, 1'b0, 32'h0);
        push(32'h5555AAAA, 1'b0, "gpr_toggle");
        for (int i = 0; i < 3; i++) begin
            dbg_stall_i = ~dbg_stall_i;
            step();
            check($sformatf("gpr_toggle_stall_%0d", i), {31'b0, du_stall}, 32'h1);
        end
        cpu_halted  = 1'b1;
        step();
        dbg_stall_i = 1'b0;
        check("gpr_toggle_strb", {31'b0, du_gpr_strb}, 32'h1);
        check("gpr_toggle_addr", {20'b0, du_addr}, 32'h010);
        step();
        check("gpr_toggle_ack", {31'b0, dbg_ack}, 32'h1);
        cpu_halted = 1'b0;
        gap();

        // Strobe held for 10 cycles yields a single ack
        du_int_rdata = 32'h77;
        acks_before = ack_count;
        req(16'h0000, 1'b0, 32'h0);
        push(32'h77, 1'b0, "held_strb");
        step(10);
        dbg_strb = 1'b0;
        step(3);
        check("held_strb_acks", ack_count - acks_before, 32'd1);

        // Reset in WAIT_CSR aborts the access
        dbg_stall_i = 1'b1;
        cpu_halted  = 1'b1;
        step(2);
        du_csr_rdata = 32'hDEAD;
        req(16'h2004, 1'b0, 32'h0);
        step(3);
        rstn = 1'b0;
        dbg_strb = 1'b0;
        dbg_stall_i = 1'b0;
        cpu_halted = 1'b0;
        #1;
        check("abort_ctrl", {25'b0, dbg_ack, dbg_err, du_stall, du_int_strb, du_gpr_strb,
                             du_csr_strb, du_we}, 32'h0);
        check("abort_addr", {20'b0, du_addr}, 32'h0);
        check("abort_dbg_dato", dbg_dato, 32'h0);
        step(2);
        rstn = 1'b1;
        acks_before = ack_count;
        any_strb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            any_strb = any_strb | du_int_strb | du_gpr_strb | du_csr_strb;
        end
        check("abort_no_strb", {31'b0, any_strb}, 32'h0);
        check("abort_no_ack", ack_count - acks_before, 32'd0);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
